mm_sequencer: RTL
=================

// Module: mm_sequencer
// PURPOSE
//  Control FSM for the 3x3 operand memory bank and the MAC array behind it.
//  Accepts a valid/ready word stream: 9 W words (row-major), then 9 X words.
//  Writes them into the bank, then issues unload1/2/3 phases with MAC enables.
//  Signals completion to the host. Sits between the host/stream source and memory_bank + MAC array.
// PARAMETERS
//  DW          4  operand word width (bank data width)
//  UNLOAD_HOLD 1  cycles each unloadK phase is held (>=1)
//  MAC_LAT     2  pipeline latency of MAC array after last mac_en (>=0)
// PORTS
//  clk          in   1   rising-edge clock
//  clear        in   1   synchronous, active-high reset
//  in_valid     in   1   stream word valid
//  in_data      in   DW  stream word
//  in_ready     out  1   sequencer accepts word this cycle
//  abort        in   1   sync request: drop the job and return to IDLE
//  load_w       out  1   bank write strobe, W matrix
//  load_x       out  1   bank write strobe, X matrix
//  bank_data    out  DW  bank write data (= in_data, combinational)
//  bank_clear   out  1   bank contents clear strobe
//  unload1..3   out  1   bank read phase selects (one-hot or all zero)
//  mac_en       out  1   MAC array accumulate enable
//  acc_clr      out  1   MAC accumulator clear
//  busy         out  1   job in progress (state != IDLE)
//  done         out  1   one-cycle pulse at job completion
// BEHAVIOUR
//  Reset (clear=1 at posedge):
//   - state=IDLE, counters=0.
//   - Outputs 0, except in_ready=1 after reset and bank_clear=1 during the reset cycle.
//   - clear has priority over every other input.
//  States: IDLE, LOAD_W, LOAD_X, PRE, UNLOAD, DRAIN, DONE.
//  Accept = in_valid & in_ready.
//   - load_w/load_x are combinational in the accept cycle.
//   - in_ready=1 only in IDLE/LOAD_W/LOAD_X.
//  IDLE:
//   - Accept writes W[0] (load_w=1), word_cnt<=1, goes to LOAD_W.
//  LOAD_W:
//   - Each accept drives load_w=1 and increments word_cnt.
//   - Accept at word_cnt==8 (9th word): word_cnt<=0, goes to LOAD_X.
//  LOAD_X:
//   - Same as LOAD_W with load_x.
//   - 9th accept goes to PRE.
//   - Stalls (in_valid=0) hold state and counters indefinitely.
//  PRE:
//   - One cycle, acc_clr=1.
//   - Goes to UNLOAD with phase=1.
//  UNLOAD:
//   - unload<phase>=1 and mac_en=1 for exactly UNLOAD_HOLD cycles per phase.
//   - Phases run 1 -> 2 -> 3, with no gap cycles between them.
//   - Total UNLOAD time = 3*UNLOAD_HOLD cycles.
//  DRAIN:
//   - MAC_LAT cycles with all strobes 0.
//   - If MAC_LAT=0, DRAIN is skipped.
//  DONE:
//   - One cycle: done=1, bank_clear=1.
//   - Then IDLE.
//  Latency, last X accept to done: 1 + 3*UNLOAD_HOLD + MAC_LAT + 1 cycles (7 at defaults).
//  busy=1 in every state except IDLE. busy is registered from the next state, so it is high in the cycle after the IDLE accept.
//  abort (sampled any non-IDLE state):
//   - Next state IDLE, bank_clear=1 for one cycle, done stays 0.
//   - The accept, if any, in the abort cycle is still written to the bank.
//   - abort in IDLE is ignored.
//  unload1..3 are never asserted together. mac_en equals unload1|unload2|unload3.
//  word_cnt is 4 bits; hold counter is clog2(max(UNLOAD_HOLD,MAC_LAT)+1) bits; no wrap is reachable.
// CONFIGURATION
//  MM_SEQ_PERF_CNT_EN defined:
//   - Adds outputs job_cycles[15:0] and job_cycles_vld.
//   - Counts cycles from the IDLE accept to DONE, inclusive.
//   - Latched and published with job_cycles_vld=1 in the DONE cycle; saturates at 16'hFFFF.
//   - Clears on clear; abort discards the count.
//  Not defined: ports and counter are absent; core behaviour is identical.
// STRUCTURE
//  mm_pkg:
//   - state enum encoding.
//   - localparam MM_N=3, MM_WORDS=9, MM_WCNT_W=4.
//  Sub-module mm_phase_timer: loadable down-counter with zero flag, shared by UNLOAD hold and DRAIN.
//  FSM, word counter and strobe decode stay in mm_sequencer.
// TESTING
//  T1 Reset:
//   - clear=1 for 2 cycles.
//   - Expect: all strobes 0, bank_clear=1, busy=0, in_ready=1 the cycle after release.
//  T2 Nominal job:
//   - Stream W=1..9, then X=9..1, in_valid held high.
//   - Expect: load_w on 9 cycles, then load_x on 9 cycles, acc_clr 1 cycle.
//   - Expect: unload1/2/3 one cycle each, done 7 cycles after the 18th accept.
//  T3 Back-pressure/stall:
//   - Drop in_valid for 5 cycles after W word 4.
//   - Expect: state held, no strobes, 5th W word written next accept, total 18 writes.
//  T4 Abort mid-load:
//   - abort with the 3rd X word.
//   - Expect: that word written, bank_clear pulse, IDLE, no done, next job starts with load_w.
//  T5 Params UNLOAD_HOLD=2, MAC_LAT=0:
//   - Expect: each unloadK high 2 cycles, no DRAIN, done 8 cycles after last X accept.
//  T6 MM_SEQ_PERF_CNT_EN (defaults, no stalls):
//   - Expect: job_cycles=25 with job_cycles_vld in the done cycle.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared sizes, state encodings and control payload for the 3x3 operand sequencer.
package mm_pkg;

    localparam int unsigned MM_N       = 3;
    localparam int unsigned MM_WORDS   = MM_N * MM_N;
    localparam int unsigned MM_WCNT_W  = 4;
    localparam int unsigned MM_PHASE_W = 2;
    localparam int unsigned MM_JC_W    = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_LOAD_X = 3'd2;
    localparam logic [2:0] ST_PRE    = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    // Registered control strobes toward the bank, MAC array and host.
    typedef struct packed {
        logic [MM_N-1:0] unload;
        logic            mac_en;
        logic            acc_clr;
        logic            busy;
        logic            done;
        logic            bank_clear;
    } mm_ctl_t;

    localparam mm_ctl_t MM_CTL_RST = '{
        unload:     '0,
        mac_en:     1'b0,
        acc_clr:    1'b0,
        busy:       1'b0,
        done:       1'b0,
        bank_clear: 1'b1
    };

    function automatic int unsigned mm_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [MM_JC_W-1:0] mm_sat_inc(input logic [MM_JC_W-1:0] v);
        return (v == '1) ? v : v + MM_JC_W'(1);
    endfunction

endpackage

// File: rtl/mm_sequencer_if.sv
// Valid/ready operand word stream feeding the sequencer.
interface mm_sequencer_if #(
    parameter int unsigned DW = 4
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mm_phase_timer.sv
// Loadable down-counter with registered zero flag; times UNLOAD phases and DRAIN.
module mm_phase_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_q;

    always_comb begin : cnt_next
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin : cnt_reg
        if (clear) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/mm_sequencer.sv
// Control FSM for the 3x3 operand bank and MAC array: load W/X, unload 3 phases, drain, done.
// Optional MM_SEQ_PERF_CNT_EN adds a saturating per-job cycle counter.
module mm_sequencer
    import mm_pkg::*;
#(
    parameter int unsigned DW          = 4,
    parameter int unsigned UNLOAD_HOLD = 1,
    parameter int unsigned MAC_LAT     = 2
) (
    input  logic                clk,
    input  logic                clear,
    mm_sequencer_if.slave       s_if,
    input  logic                abort_i,
    output logic                load_w_c_o,
    output logic                load_x_c_o,
    output logic [DW-1:0]       bank_data_c_o,
    output logic                bank_clear_o,
    output logic                unload1_o,
    output logic                unload2_o,
    output logic                unload3_o,
    output logic                mac_en_o,
    output logic                acc_clr_o,
    output logic                busy_o,
    output logic                done_o
`ifdef MM_SEQ_PERF_CNT_EN
    ,
    output logic [MM_JC_W-1:0]  job_cycles_o,
    output logic                job_cycles_vld_o
`endif
);

    localparam int unsigned TMR_W = $clog2(mm_max(UNLOAD_HOLD, MAC_LAT) + 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(UNLOAD_HOLD - 1);
    localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    logic [2:0]            state_q, state_d;
    logic [MM_WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [MM_PHASE_W-1:0] phase_q, phase_d;
    logic                  in_ready_q;
    mm_ctl_t               ctl_q, ctl_d;
    logic                  accept;
    logic                  abort_take;
    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_zero;

    assign accept = s_if.in_valid & in_ready_q & ~clear;

    mm_phase_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .clear      (clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Next state, counters, timer control, and registered-strobe decode of the next state.
    always_comb begin : fsm_next
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        phase_d    = phase_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        abort_take = 1'b0;
        ctl_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD_W;
                    wcnt_d  = MM_WCNT_W'(1);
                end
            end
            ST_LOAD_W, ST_LOAD_X: begin
                if (accept) begin
                    if (wcnt_q == MM_WCNT_W'(MM_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = (state_q == ST_LOAD_W) ? ST_LOAD_X : ST_PRE;
                    end else begin
                        wcnt_d = wcnt_q + MM_WCNT_W'(1);
                    end
                end
            end
            ST_PRE: begin
                state_d  = ST_UNLOAD;
                phase_d  = MM_PHASE_W'(1);
                tmr_load = 1'b1;
                tmr_val  = HOLD_LOAD;
            end
            ST_UNLOAD: begin
                if (tmr_zero) begin
                    if (phase_q == MM_PHASE_W'(MM_N)) begin
                        phase_d = '0;
                        if (MAC_LAT == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_DRAIN;
                            tmr_load = 1'b1;
                            tmr_val  = DRAIN_LOAD;
                        end
                    end else begin
                        phase_d  = phase_q + MM_PHASE_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (tmr_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over normal sequencing; any accept this cycle still reaches the bank.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            wcnt_d     = '0;
            phase_d    = '0;
            abort_take = 1'b1;
        end

        ctl_d.busy       = (state_d != ST_IDLE);
        ctl_d.acc_clr    = (state_d == ST_PRE);
        ctl_d.done       = (state_d == ST_DONE);
        ctl_d.bank_clear = (state_d == ST_DONE) | abort_take;
        if (state_d == ST_UNLOAD) begin
            ctl_d.mac_en = 1'b1;
            for (int k = 0; k < int'(MM_N); k++) begin
                ctl_d.unload[k] = (phase_d == MM_PHASE_W'(k + 1));
            end
        end
    end

    always_ff @(posedge clk) begin : fsm_reg
        if (clear) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            phase_q    <= '0;
            in_ready_q <= 1'b1;
            ctl_q      <= MM_CTL_RST;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            phase_q    <= phase_d;
            in_ready_q <= (state_d == ST_IDLE) | (state_d == ST_LOAD_W) | (state_d == ST_LOAD_X);
            ctl_q      <= ctl_d;
        end
    end

    assign s_if.in_ready = in_ready_q;
    assign load_w_c_o    = accept & ((state_q == ST_IDLE) | (state_q == ST_LOAD_W));
    assign load_x_c_o    = accept & (state_q == ST_LOAD_X);
    assign bank_data_c_o = s_if.in_data;
    assign bank_clear_o  = ctl_q.bank_clear;
    assign unload1_o     = ctl_q.unload[0];
    assign unload2_o     = ctl_q.unload[1];
    assign unload3_o     = ctl_q.unload[2];
    assign mac_en_o      = ctl_q.mac_en;
    assign acc_clr_o     = ctl_q.acc_clr;
    assign busy_o        = ctl_q.busy;
    assign done_o        = ctl_q.done;

`ifdef MM_SEQ_PERF_CNT_EN
    logic [MM_JC_W-1:0] cyc_q, cyc_d;
    logic [MM_JC_W-1:0] jc_q;
    logic               jc_vld_q;

    // cyc_q holds the cycles of the current job elapsed before this one.
    always_comb begin : perf_next
        cyc_d = '0;
        if (state_q == ST_IDLE) begin
            cyc_d = accept ? MM_JC_W'(1) : '0;
        end else begin
            cyc_d = mm_sat_inc(cyc_q);
        end
    end

    always_ff @(posedge clk) begin : perf_reg
        if (clear) begin
            cyc_q    <= '0;
            jc_q     <= '0;
            jc_vld_q <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            jc_vld_q <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                jc_q <= mm_sat_inc(cyc_d);
            end
        end
    end

    assign job_cycles_o     = jc_q;
    assign job_cycles_vld_o = jc_vld_q;
`endif

endmodule
